// File: rtl/led_pkg.sv
// Shared types and constants for the LED status driver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package led_pkg;

    // Game phase as seen by the LED driver
    typedef enum logic [1:0] {
        SETUP = 2'd0,
        PLAY  = 2'd1,
        WON   = 2'd2,
        LOST  = 2'd3
    } state_t;

    // 1 Hz blink half-period at 100 MHz
    localparam int unsigned DEF_BLINK_DIV = 50_000_000;

    // Phase bit encoding: 1 = ON half-period, 0 = OFF half-period
    localparam logic PHASE_ON = 1'b1;

    // Loss patterns; bit 0 is lit in the even pattern
    localparam logic [63:0] EVEN_PAT = {32{2'b01}};
    localparam logic [63:0] ODD_PAT  = {32{2'b10}};

endpackage

// File: rtl/led_blink_timer.sv
// Blink phase generator: phase toggles every BLINK_DIV cycles.
// Latency: restart takes effect on the same edge (count 0, phase ON).
// Backpressure: none; free-running while restart is low.
module led_blink_timer
    import led_pkg::*;
#(
    parameter int unsigned BLINK_DIV = DEF_BLINK_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic phase
);

    localparam int unsigned CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [CW-1:0] cnt;
    logic          wrap;

    // Compare at 32 bits so the terminal count is never truncated
    assign wrap = (32'(cnt) == 32'(BLINK_DIV - 1));

    // Count 0..BLINK_DIV-1, flip phase on wrap; restart forces a fresh ON half-period
    always_ff @(posedge clk) begin
        if (rst || restart) begin
            cnt   <= '0;
            phase <= PHASE_ON;
        end else if (wrap) begin
            cnt   <= '0;
            phase <= ~phase;
        end else begin
            cnt   <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/led_status_ctrl.sv
// Registered LED bank driver: game-phase FSM, thermometer/move/blink views, flags on top.
// Latency: 1 cycle from any input to led; state changes show on led one cycle after the state edge.
// Backpressure: none; inputs are sampled every cycle.
module led_status_ctrl
    import led_pkg::*;
#(
    parameter int          NUM_LEDS  = 16,
    parameter int          THERM_W   = 8,
    parameter int          FLAG_W    = 4,
    parameter int          MOVE_W    = 8,
    parameter int unsigned BLINK_DIV = DEF_BLINK_DIV
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [3:0]          color_num,
    input  logic [FLAG_W-1:0]   flags,
    input  logic [MOVE_W-1:0]   moves,
    input  logic                game_start,
    input  logic                game_won,
    input  logic                game_lost,
    input  logic                ack,
    output logic [NUM_LEDS-1:0] led
);

    // Everything below the flag field
    localparam logic [NUM_LEDS-1:0] NF_MASK  = {{FLAG_W{1'b0}}, {(NUM_LEDS-FLAG_W){1'b1}}};
    localparam logic [NUM_LEDS-1:0] EVEN_L   = EVEN_PAT[NUM_LEDS-1:0];
    localparam logic [NUM_LEDS-1:0] ODD_L    = ODD_PAT[NUM_LEDS-1:0];

    state_t               state;
    logic                 phase;
    logic                 restart;
    logic [THERM_W-1:0]   therm;
    logic [NUM_LEDS-1:0]  disp;

    // Game phase FSM; won beats lost when both arrive together
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SETUP;
        end else begin
            case (state)
                SETUP: if (game_start) state <= PLAY;
                PLAY: begin
                    if (game_won)       state <= WON;
                    else if (game_lost) state <= LOST;
                end
                WON, LOST: if (ack) state <= SETUP;
                default: state <= SETUP;
            endcase
        end
    end

    // Hold the timer cleared outside WON/LOST and on the exit edge, so every
    // entry starts a full ON half-period and a wrap coinciding with ack is dropped
    assign restart = (state == SETUP) || (state == PLAY) || ack;

    led_blink_timer #(
        .BLINK_DIV (BLINK_DIV)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .restart (restart),
        .phase   (phase)
    );

    // Thermometer: lowest min(color_num, THERM_W) bits lit
    always_comb begin
        therm = '0;
        for (int i = 0; i < THERM_W; i++) begin
            therm[i] = (int'(color_num) > i);
        end
    end

    // Field mux for the current game phase, flags overlaid on the top bits
    always_comb begin
        disp = '0;
        case (state)
            SETUP: disp[THERM_W-1:0] = therm;
            PLAY:  disp[MOVE_W-1:0]  = moves;
            WON:   disp = (phase == PHASE_ON) ? NF_MASK : '0;
            LOST:  disp = (phase == PHASE_ON) ? (EVEN_L & NF_MASK) : (ODD_L & NF_MASK);
            default: disp = '0;
        endcase
        disp[NUM_LEDS-1 -: FLAG_W] = flags;
    end

    // Output register
    always_ff @(posedge clk) begin
        if (rst) led <= '0;
        else     led <= disp;
    end

endmodule
